// File: rtl/rf_pkg.sv
// ----------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the operand-fetch register file:
//   - fwd_sel_e    : per-read-port operand source select
//   - XLEN_DEF     : default data width
//   - NREGS_DEF    : default architectural register count
//   - MAX_WPORTS   : upper bound on write-back ports handled by highest_set()
//   - highest_set(): index of the highest set bit, -1 when none set; used to
//                    resolve same-address write-back ports (highest port wins)
// ----------------------------------------------------------------------------
package rf_pkg;

    localparam int unsigned XLEN_DEF   = 32;
    localparam int unsigned NREGS_DEF  = 32;
    localparam int unsigned MAX_WPORTS = 8;

    // 2'b11 is deliberately not enumerated: it behaves exactly like FWD_RF.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_ALU = 2'b10
    } fwd_sel_e;

    function automatic int highest_set(input logic [MAX_WPORTS-1:0] v);
        int idx;
        idx = -1;
        for (int unsigned k = 0; k < MAX_WPORTS; k++) begin
            if (v[k]) idx = int'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// ----------------------------------------------------------------------------
// rf_scoreboard
// Per-register busy tracking for long-latency producers plus hazard detection
// for the operand-fetch stage.
//
// Ports
//   clk, reset    : clock, synchronous active-high reset
//   i_halt        : freeze busy vector; also blocks accept
//   i_dec_valid   : decoded instruction present
//   i_rs_addr     : NREAD source addresses, packed
//   i_rs_used     : NREAD flags, port is a real operand
//   i_fwd_sel     : NREAD 2-bit forward selects, packed
//   i_rd_issue    : instruction writes rd
//   i_rd_addr     : destination register
//   i_wb_en       : NWRITE write-back enables
//   i_wb_addr     : NWRITE write-back addresses, packed
//   o_stall       : combinational RAW/WAW stall (valid even while halted)
//   o_accept      : instruction leaves decode this cycle
//   o_busy        : current busy vector
// ----------------------------------------------------------------------------
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int unsigned NREGS         = NREGS_DEF,
    parameter  int unsigned NREAD         = 3,
    parameter  int unsigned NWRITE        = 2,
    parameter  int unsigned HARDWIRE_ZERO = 1,
    localparam int unsigned AW            = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_halt,
    input  logic                   i_dec_valid,
    input  logic [NREAD*AW-1:0]    i_rs_addr,
    input  logic [NREAD-1:0]       i_rs_used,
    input  logic [NREAD*2-1:0]     i_fwd_sel,
    input  logic                   i_rd_issue,
    input  logic [AW-1:0]          i_rd_addr,
    input  logic [NWRITE-1:0]      i_wb_en,
    input  logic [NWRITE*AW-1:0]   i_wb_addr,
    output logic                   o_stall,
    output logic                   o_accept,
    output logic [NREGS-1:0]       o_busy
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_clr;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_busy_next;
    logic [NREAD-1:0] w_raw;
    logic             w_rd_wb_hit;
    logic             w_waw;
    logic             w_rd_zero;

    // A same-cycle write-back to a busy source resolves the hazard because the
    // bypass path delivers that data directly.
    for (genvar g = 0; g < NREAD; g++) begin : g_raw
        logic [AW-1:0] w_rs;
        logic [1:0]    w_sel;
        logic          w_wb_hit;

        assign w_rs  = i_rs_addr[g*AW +: AW];
        assign w_sel = i_fwd_sel[g*2 +: 2];

        always_comb begin
            w_wb_hit = 1'b0;
            for (int unsigned k = 0; k < NWRITE; k++) begin
                if (i_wb_en[k] && (i_wb_addr[k*AW +: AW] == w_rs)) w_wb_hit = 1'b1;
            end
        end

        // Forwarded operands never wait on the register file.
        assign w_raw[g] = i_dec_valid & i_rs_used[g] & r_busy[w_rs]
                        & (w_sel != FWD_MEM) & (w_sel != FWD_ALU) & ~w_wb_hit;
    end

    always_comb begin
        w_rd_wb_hit = 1'b0;
        for (int unsigned k = 0; k < NWRITE; k++) begin
            if (i_wb_en[k] && (i_wb_addr[k*AW +: AW] == i_rd_addr)) w_rd_wb_hit = 1'b1;
        end
    end

    assign w_waw     = i_dec_valid & i_rd_issue & r_busy[i_rd_addr] & ~w_rd_wb_hit;
    assign o_stall   = (|w_raw) | w_waw;
    assign o_accept  = i_dec_valid & ~o_stall & ~i_halt;
    assign w_rd_zero = (HARDWIRE_ZERO != 0) && (i_rd_addr == '0);

    // Set is applied after clear so a new issue wins over a retiring write.
    always_comb begin
        w_clr = '0;
        w_set = '0;
        for (int unsigned k = 0; k < NWRITE; k++) begin
            if (i_wb_en[k]) w_clr[i_wb_addr[k*AW +: AW]] = 1'b1;
        end
        if (o_accept && i_rd_issue && !w_rd_zero) w_set[i_rd_addr] = 1'b1;
        w_busy_next = (r_busy & ~w_clr) | w_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else if (!i_halt) begin
            r_busy <= w_busy_next;
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/operand_fetch_rf.sv
// ----------------------------------------------------------------------------
// operand_fetch_rf
// Parametrised register file and operand-fetch stage between decode and
// execute. NREAD combinational read ports with write-through bypass and
// ALU/Mem forwarding, NWRITE posedge write-back ports, a busy scoreboard for
// multi-cycle producers and a registered ID/EX operand output.
//
// Ports
//   clk, reset : clock, synchronous active-high reset (overrides halt)
//   halt       : freeze RF, busy, op_valid, op_data; write-backs ignored
//   dec_valid  : decoded instruction present
//   rs_addr    : NREAD source addresses, packed AW bits each
//   rs_used    : NREAD real-operand flags
//   fwd_sel    : NREAD 2-bit selects: 00 RF, 01 Mem, 10 ALU, 11 RF
//   fwd_alu    : forwarded ALU result
//   fwd_mem    : forwarded Mem result
//   rd_issue   : instruction will write rd
//   rd_addr    : destination register
//   wb_en      : NWRITE write-back enables
//   wb_addr    : NWRITE write-back addresses, packed
//   wb_data    : NWRITE write-back data, packed
//   stall      : combinational hazard stall to fetch/decode
//   op_valid   : registered, op_data valid for execute
//   op_data    : registered operands, port i in bits [i*XLEN +: XLEN]
//   busy       : scoreboard state
// ----------------------------------------------------------------------------
module operand_fetch_rf
    import rf_pkg::*;
#(
    parameter  int unsigned XLEN          = XLEN_DEF,
    parameter  int unsigned NREGS         = NREGS_DEF,
    parameter  int unsigned NREAD         = 3,
    parameter  int unsigned NWRITE        = 2,
    parameter  int unsigned HARDWIRE_ZERO = 1,
    localparam int unsigned AW            = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     halt,
    input  logic                     dec_valid,
    input  logic [NREAD*AW-1:0]      rs_addr,
    input  logic [NREAD-1:0]         rs_used,
    input  logic [NREAD*2-1:0]       fwd_sel,
    input  logic [XLEN-1:0]          fwd_alu,
    input  logic [XLEN-1:0]          fwd_mem,
    input  logic                     rd_issue,
    input  logic [AW-1:0]            rd_addr,
    input  logic [NWRITE-1:0]        wb_en,
    input  logic [NWRITE*AW-1:0]     wb_addr,
    input  logic [NWRITE*XLEN-1:0]   wb_data,
    output logic                     stall,
    output logic                     op_valid,
    output logic [NREAD*XLEN-1:0]    op_data,
    output logic [NREGS-1:0]         busy
);

    logic [XLEN-1:0]       r_rf [NREGS];
    logic                  r_op_valid;
    logic [NREAD*XLEN-1:0] r_op_data;
    logic [NREAD*XLEN-1:0] w_rd_data;
    logic                  w_accept;
    logic                  w_stall;
    logic [NREGS-1:0]      w_busy;

    rf_scoreboard #(
        .NREGS         (NREGS),
        .NREAD         (NREAD),
        .NWRITE        (NWRITE),
        .HARDWIRE_ZERO (HARDWIRE_ZERO)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .i_halt      (halt),
        .i_dec_valid (dec_valid),
        .i_rs_addr   (rs_addr),
        .i_rs_used   (rs_used),
        .i_fwd_sel   (fwd_sel),
        .i_rd_issue  (rd_issue),
        .i_rd_addr   (rd_addr),
        .i_wb_en     (wb_en),
        .i_wb_addr   (wb_addr),
        .o_stall     (w_stall),
        .o_accept    (w_accept),
        .o_busy      (w_busy)
    );

    // Ports are visited in ascending order so the highest port's update is the
    // last non-blocking assignment and therefore wins on an address clash.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                r_rf[r] <= '0;
            end
        end else if (!halt) begin
            for (int unsigned k = 0; k < NWRITE; k++) begin
                if (wb_en[k] && !((HARDWIRE_ZERO != 0) && (wb_addr[k*AW +: AW] == '0))) begin
                    r_rf[wb_addr[k*AW +: AW]] <= wb_data[k*XLEN +: XLEN];
                end
            end
        end
    end

    // Read path priority: hardwired zero, then explicit forward, then
    // same-cycle write-back bypass, then stored value.
    for (genvar g = 0; g < NREAD; g++) begin : g_read
        logic [AW-1:0]         w_rs;
        logic [1:0]            w_sel;
        logic [MAX_WPORTS-1:0] w_hit;
        int                    w_idx;
        logic [XLEN-1:0]       w_val;

        assign w_rs  = rs_addr[g*AW +: AW];
        assign w_sel = fwd_sel[g*2 +: 2];

        always_comb begin
            w_hit = '0;
            for (int unsigned k = 0; k < NWRITE; k++) begin
                if (wb_en[k] && (wb_addr[k*AW +: AW] == w_rs)) w_hit[k] = 1'b1;
            end
        end

        assign w_idx = highest_set(w_hit);

        always_comb begin
            w_val = r_rf[w_rs];
            if (|w_hit) w_val = wb_data[w_idx*XLEN +: XLEN];
            if (w_sel == FWD_MEM) begin
                w_val = fwd_mem;
            end else if (w_sel == FWD_ALU) begin
                w_val = fwd_alu;
            end
            if ((HARDWIRE_ZERO != 0) && (w_rs == '0)) w_val = '0;
        end

        assign w_rd_data[g*XLEN +: XLEN] = w_val;
    end

    // op_valid is frozen by halt rather than dropped, so execute sees the same
    // ID/EX contents when the pipeline resumes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op_valid <= 1'b0;
            r_op_data  <= '0;
        end else if (!halt) begin
            r_op_valid <= w_accept;
            if (w_accept) r_op_data <= w_rd_data;
        end
    end

    assign stall    = w_stall;
    assign op_valid = r_op_valid;
    assign op_data  = r_op_data;
    assign busy     = w_busy;

endmodule

// File: tb/tb_operand_fetch_rf.sv
module tb_operand_fetch_rf;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NREAD  = 3;
    localparam int NWRITE = 2;
    localparam int AW     = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   reset, halt, dec_valid, rd_issue;
    logic [NREAD*AW-1:0]    rs_addr;
    logic [NREAD-1:0]       rs_used;
    logic [NREAD*2-1:0]     fwd_sel;
    logic [XLEN-1:0]        fwd_alu, fwd_mem;
    logic [AW-1:0]          rd_addr;
    logic [NWRITE-1:0]      wb_en;
    logic [NWRITE*AW-1:0]   wb_addr;
    logic [NWRITE*XLEN-1:0] wb_data;

    // index 0: integer file (HARDWIRE_ZERO=1), index 1: FP file (HARDWIRE_ZERO=0)
    logic                   stall_q [2];
    logic                   opv_q   [2];
    logic [NREAD*XLEN-1:0]  opd_q   [2];
    logic [NREGS-1:0]       busy_q  [2];

    operand_fetch_rf #(
        .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE), .HARDWIRE_ZERO(1)
    ) u_dut_int (
        .clk(clk), .reset(reset), .halt(halt), .dec_valid(dec_valid),
        .rs_addr(rs_addr), .rs_used(rs_used), .fwd_sel(fwd_sel),
        .fwd_alu(fwd_alu), .fwd_mem(fwd_mem), .rd_issue(rd_issue), .rd_addr(rd_addr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .stall(stall_q[0]), .op_valid(opv_q[0]), .op_data(opd_q[0]), .busy(busy_q[0])
    );

    operand_fetch_rf #(
        .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE), .HARDWIRE_ZERO(0)
    ) u_dut_fp (
        .clk(clk), .reset(reset), .halt(halt), .dec_valid(dec_valid),
        .rs_addr(rs_addr), .rs_used(rs_used), .fwd_sel(fwd_sel),
        .fwd_alu(fwd_alu), .fwd_mem(fwd_mem), .rd_issue(rd_issue), .rd_addr(rd_addr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .stall(stall_q[1]), .op_valid(opv_q[1]), .op_data(opd_q[1]), .busy(busy_q[1])
    );

    // Reference model: architectural state of both files.
    logic [XLEN-1:0]       m_rf   [2][NREGS];
    logic [NREGS-1:0]      m_busy [2];
    logic                  m_opv  [2];
    logic [NREAD*XLEN-1:0] m_opd  [2];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [NREAD*XLEN-1:0] obs,
                       input logic [NREAD*XLEN-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic wb_to(input logic [AW-1:0] a);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NWRITE; k++)
            if (wb_en[k] && wb_addr[k*AW +: AW] == a) hit = 1'b1;
        return hit;
    endfunction

    function automatic logic [XLEN-1:0] m_read(input int h, input int i);
        logic [AW-1:0]   rs;
        logic [1:0]      sel;
        logic [XLEN-1:0] v;
        rs  = rs_addr[i*AW +: AW];
        sel = fwd_sel[i*2 +: 2];
        if (h == 0 && rs == 0) return '0;
        if (sel == 2'b01) return fwd_mem;
        if (sel == 2'b10) return fwd_alu;
        v = m_rf[h][rs];
        for (int k = 0; k < NWRITE; k++)
            if (wb_en[k] && wb_addr[k*AW +: AW] == rs) v = wb_data[k*XLEN +: XLEN];
        return v;
    endfunction

    function automatic logic m_stall(input int h);
        logic s;
        logic [AW-1:0] rs;
        logic [1:0] sel;
        s = 1'b0;
        for (int i = 0; i < NREAD; i++) begin
            rs  = rs_addr[i*AW +: AW];
            sel = fwd_sel[i*2 +: 2];
            if (dec_valid && rs_used[i] && m_busy[h][rs] && (sel == 2'b00 || sel == 2'b11)
                && !wb_to(rs)) s = 1'b1;
        end
        if (dec_valid && rd_issue && m_busy[h][rd_addr] && !wb_to(rd_addr)) s = 1'b1;
        return s;
    endfunction

    // Inputs are set shortly after a posedge; stall is checked before the next
    // edge, registered outputs 1 time unit after it.
    task automatic do_cycle();
        logic                  es;
        logic                  acc;
        logic [NREAD*XLEN-1:0] rv;
        logic [AW-1:0]         a;
        #1;
        for (int h = 0; h < 2; h++) begin
            es = m_stall(h);
            chk(h == 0 ? "stall_int" : "stall_fp", stall_q[h], es);
            if (reset) begin
                for (int r = 0; r < NREGS; r++) m_rf[h][r] = '0;
                m_busy[h] = '0;
                m_opv[h]  = 1'b0;
                m_opd[h]  = '0;
            end else if (!halt) begin
                acc = dec_valid && !es;
                for (int i = 0; i < NREAD; i++) rv[i*XLEN +: XLEN] = m_read(h, i);
                for (int k = 0; k < NWRITE; k++) begin
                    a = wb_addr[k*AW +: AW];
                    if (wb_en[k] && !(h == 0 && a == 0)) m_rf[h][a] = wb_data[k*XLEN +: XLEN];
                    if (wb_en[k]) m_busy[h][a] = 1'b0;
                end
                if (acc && rd_issue && !(h == 0 && rd_addr == 0)) m_busy[h][rd_addr] = 1'b1;
                m_opv[h] = acc;
                if (acc) m_opd[h] = rv;
            end
        end
        @(posedge clk);
        #1;
        for (int h = 0; h < 2; h++) begin
            chk(h == 0 ? "op_valid_int" : "op_valid_fp", opv_q[h], m_opv[h]);
            chk(h == 0 ? "op_data_int"  : "op_data_fp",  opd_q[h], m_opd[h]);
            chk(h == 0 ? "busy_int"     : "busy_fp",     busy_q[h], m_busy[h]);
        end
    endtask

    task automatic idle();
        reset = 1'b0; halt = 1'b0; dec_valid = 1'b0; rd_issue = 1'b0; rd_addr = '0;
        rs_addr = '0; rs_used = '0; fwd_sel = '0;
        wb_en = '0; wb_addr = '0; wb_data = '0;
        fwd_alu = $urandom; fwd_mem = $urandom;
    endtask

    task automatic set_rd(input int i, input logic [AW-1:0] a, input logic [1:0] sel);
        rs_addr[i*AW +: AW] = a;
        fwd_sel[i*2 +: 2]   = sel;
        rs_used[i]          = 1'b1;
    endtask

    task automatic set_wb(input int k, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wb_en[k]                = 1'b1;
        wb_addr[k*AW +: AW]     = a;
        wb_data[k*XLEN +: XLEN] = d;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int h = 0; h < 2; h++) begin
            for (int r = 0; r < NREGS; r++) m_rf[h][r] = '0;
            m_busy[h] = '0; m_opv[h] = 1'b0; m_opd[h] = '0;
        end
        idle();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        // Reset state, then a read of every port returns 0.
        chk("reset_op_valid", opv_q[0], 1'b0);
        chk("reset_op_data",  opd_q[0], '0);
        chk("reset_busy",     busy_q[1], '0);
        idle(); dec_valid = 1'b1;
        set_rd(0, 5'd4, 2'b00); set_rd(1, 5'd17, 2'b11); set_rd(2, 5'd31, 2'b00);
        do_cycle();
        chk("reset_read_fp", opd_q[1], '0);

        // Write-through bypass on the same cycle as the write.
        idle(); dec_valid = 1'b1;
        set_rd(0, 5'd5, 2'b00); set_wb(0, 5'd5, 32'hDEADBEEF);
        do_cycle();
        chk("bypass_data", opd_q[0][31:0], 32'hDEADBEEF);
        chk("bypass_valid", opv_q[0], 1'b1);

        // Same-address write-back on both ports: port 1 wins.
        idle(); dec_valid = 1'b1;
        set_rd(0, 5'd7, 2'b00); set_wb(0, 5'd7, 32'h1111); set_wb(1, 5'd7, 32'h2222);
        do_cycle();
        chk("prio_bypass", opd_q[0][31:0], 32'h2222);
        idle(); dec_valid = 1'b1; set_rd(2, 5'd7, 2'b00);
        do_cycle();
        chk("prio_stored", opd_q[1][95:64], 32'h2222);

        // Scoreboard RAW stall and release by write-back.
        idle(); dec_valid = 1'b1; rd_issue = 1'b1; rd_addr = 5'd9;
        do_cycle();
        chk("busy9_set", busy_q[0][9], 1'b1);
        idle(); dec_valid = 1'b1; set_rd(1, 5'd9, 2'b00);
        for (int c = 0; c < 4; c++) begin
            do_cycle();
            chk("raw_stall", stall_q[0], 1'b1);
        end
        chk("raw_no_issue", opv_q[0], 1'b0);
        set_wb(1, 5'd9, 32'h55);
        #1;
        chk("raw_release", stall_q[0], 1'b0);
        do_cycle();
        chk("raw_data", opd_q[0][63:32], 32'h55);
        chk("raw_valid", opv_q[0], 1'b1);
        chk("busy9_clr", busy_q[0][9], 1'b0);

        // Halt freezes everything, write-back is dropped.
        idle(); halt = 1'b1; dec_valid = 1'b1;
        set_wb(0, 5'd3, 32'hAB); set_rd(0, 5'd3, 2'b00);
        do_cycle();
        chk("halt_valid", opv_q[0], 1'b1);
        chk("halt_data", opd_q[0][63:32], 32'h55);
        idle(); dec_valid = 1'b1; set_rd(0, 5'd3, 2'b00);
        do_cycle();
        chk("halt_no_write", opd_q[1][31:0], 32'h0);

        // Register 0: hardwired in the integer file, ordinary in the FP file.
        idle(); set_wb(0, 5'd0, 32'hFFFF);
        do_cycle();
        idle(); dec_valid = 1'b1; set_rd(0, 5'd0, 2'b00); rd_issue = 1'b1; rd_addr = 5'd0;
        do_cycle();
        chk("x0_int", opd_q[0][31:0], 32'h0);
        chk("x0_fp",  opd_q[1][31:0], 32'hFFFF);
        chk("x0_busy_int", busy_q[0][0], 1'b0);
        chk("x0_busy_fp",  busy_q[1][0], 1'b1);
        idle(); set_wb(1, 5'd0, 32'hFFFF);
        do_cycle();

        // Randomized traffic over a small register window to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            idle();
            reset     = ($urandom_range(0, 63) == 0);
            halt      = ($urandom_range(0, 7) == 0);
            dec_valid = ($urandom_range(0, 3) != 0);
            rd_issue  = $urandom_range(0, 1);
            rd_addr   = AW'($urandom_range(0, 7));
            for (int i = 0; i < NREAD; i++) begin
                rs_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
                fwd_sel[i*2 +: 2]   = 2'($urandom_range(0, 3));
                rs_used[i]          = $urandom_range(0, 1);
            end
            for (int k = 0; k < NWRITE; k++)
                if ($urandom_range(0, 2) == 0) set_wb(k, AW'($urandom_range(0, 7)), $urandom);
            do_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
